// File: rtl/mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_if : data-memory bus between the MEM stage and data memory.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : RISC-V MEM stage - word loads/stores, branch resolve, MEM/WB.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        res_n,
    input  wire logic        ex_mem_valid,
    input  wire logic [7:0]  ex_mem_control,
    input  wire logic [31:0] ex_mem_pc,
    input  wire logic [31:0] ex_mem_ALU_result,
    input  wire logic [31:0] ex_mem_write_data,
    input  wire logic [4:0]  ex_mem_rd,
    input  wire logic        zero_flag,
    output logic             stall,
    output logic             pc_src,
    output logic [31:0]      branch_target,
    mem_stage_if.master      dmem,
    output logic             mem_wb_valid,
    output logic [7:0]       mem_wb_control,
    output logic [31:0]      mem_wb_ALU_result,
    output logic [31:0]      mem_wb_read_data,
    output logic [4:0]       mem_wb_rd,
    output logic             misalign_fault,
    output logic             bus_error
);

    localparam int             c_CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [7:0]       r_lat_control;
    logic [4:0]       r_lat_rd;
    logic             r_timed_out;
    logic [31:0]      r_rdata;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_pc_src;
    logic [31:0]      r_branch_target;
    logic             r_wb_valid;
    logic [7:0]       r_wb_control;
    logic [31:0]      r_wb_alu;
    logic [31:0]      r_wb_rdata;
    logic [4:0]       r_wb_rd;
    logic             r_misalign;
    logic             r_bus_error;

    logic             w_mem_op;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_stall;
    logic [c_CW-1:0]  w_cnt_next;

    assign w_mem_op     = ex_mem_valid & (ex_mem_control[6] | ex_mem_control[5]);
    assign w_misaligned = (ex_mem_ALU_result[1:0] != 2'b00);
    assign w_accept     = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
    assign w_stall      = (r_state != S_IDLE) | w_accept;
    assign w_cnt_next   = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_lat_control   <= '0;
            r_lat_rd        <= '0;
            r_timed_out     <= 1'b0;
            r_rdata         <= '0;
            r_req           <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_pc_src        <= 1'b0;
            r_branch_target <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_control    <= '0;
            r_wb_alu        <= '0;
            r_wb_rdata      <= '0;
            r_wb_rd         <= '0;
            r_misalign      <= 1'b0;
            r_bus_error     <= 1'b0;
        end else begin
            r_pc_src        <= ex_mem_valid & ex_mem_control[4] & zero_flag & ~w_stall;
            r_branch_target <= ex_mem_pc;

            case (r_state)
                S_IDLE: begin
                    if (w_mem_op && w_misaligned) begin
                        r_misalign   <= 1'b1;
                        r_wb_valid   <= 1'b0;
                        r_wb_control <= '0;
                        r_wb_rdata   <= '0;
                    end else if (w_mem_op) begin
                        // A set MemWrite wins over MemRead.
                        r_lat_control <= ex_mem_control;
                        r_lat_rd      <= ex_mem_rd;
                        r_req         <= 1'b1;
                        r_we          <= ex_mem_control[5];
                        r_addr        <= ex_mem_ALU_result;
                        r_wdata       <= ex_mem_write_data;
                        r_cnt         <= '0;
                        r_timed_out   <= 1'b0;
                        r_wb_valid    <= 1'b0;
                        r_wb_control  <= '0;
                        r_wb_rdata    <= '0;
                        r_state       <= S_ACCESS;
                    end else begin
                        r_wb_valid   <= ex_mem_valid;
                        r_wb_control <= ex_mem_control;
                        r_wb_alu     <= ex_mem_ALU_result;
                        r_wb_rdata   <= '0;
                        r_wb_rd      <= ex_mem_rd;
                    end
                end

                S_ACCESS: begin
                    r_wb_valid   <= 1'b0;
                    r_wb_control <= '0;
                    r_wb_rdata   <= '0;
                    if (dmem.dmem_ready) begin
                        r_rdata <= r_we ? 32'd0 : dmem.dmem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == c_TIMEOUT) begin
                            r_req       <= 1'b0;
                            r_bus_error <= 1'b1;
                            r_timed_out <= 1'b1;
                            r_rdata     <= '0;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_wb_valid   <= ~r_timed_out;
                    r_wb_control <= r_lat_control;
                    r_wb_alu     <= r_addr;
                    r_wb_rdata   <= r_rdata;
                    r_wb_rd      <= r_lat_rd;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall             = w_stall;
    assign pc_src            = r_pc_src;
    assign branch_target     = r_branch_target;
    assign dmem.dmem_req     = r_req;
    assign dmem.dmem_we      = r_we;
    assign dmem.dmem_addr    = r_addr;
    assign dmem.dmem_wdata   = r_wdata;
    assign mem_wb_valid      = r_wb_valid;
    assign mem_wb_control    = r_wb_control;
    assign mem_wb_ALU_result = r_wb_alu;
    assign mem_wb_read_data  = r_wb_rdata;
    assign mem_wb_rd         = r_wb_rd;
    assign misalign_fault    = r_misalign;
    assign bus_error         = r_bus_error;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage RISC-V core. Sits directly downstream of EX and consumes the EX/MEM register outputs: control byte, branch target PC, ALU result, store data and zero flag.
- Performs word-wide loads and stores on a ready-handshaked data-memory bus. Stalls upstream during wait states.
- Resolves taken branches and drives the MEM/WB pipeline register feeding write-back.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles dmem_req may stay high without dmem_ready before the access is aborted.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- res_n  in  1  reset, synchronous, active-low
- ex_mem_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble)
- ex_mem_control  in  8  control byte: [6] MemRead, [5] MemWrite, [4] Branch, [3] RegWrite, [2] MemtoReg; [7],[1:0] are EX-only, passed through unused
- ex_mem_pc  in  32  branch target computed in EX
- ex_mem_ALU_result  in  32  address for load/store, or result for ALU ops
- ex_mem_write_data  in  32  store data
- ex_mem_rd  in  5  destination register index
- zero_flag  in  1  ALU zero flag from EX
- stall  out  1  upstream must hold EX/MEM contents this cycle
- pc_src  out  1  registered branch-taken pulse
- branch_target  out  32  registered target, valid when pc_src=1
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  write data
- dmem_ready  in  1  access completes in the cycle it is sampled high with dmem_req=1
- dmem_rdata  in  32  read data, valid with dmem_ready
- mem_wb_valid  out  1  MEM/WB slot valid
- mem_wb_control  out  8  control byte passed through
- mem_wb_ALU_result  out  32  ALU result passed through
- mem_wb_read_data  out  32  load data (0 for non-loads)
- mem_wb_rd  out  5  destination register passed through
- misalign_fault  out  1  sticky: a load/store had addr[1:0]!=0
- bus_error  out  1  sticky: a bus timeout occurred

Behaviour:
- Reset (res_n=0 at a rising edge): every output register = 0, FSM = IDLE, timeout counter = 0. Reset overrides everything, including an in-flight access; dmem_req drops the following cycle.
- mem_op = ex_mem_valid & (MemRead | MemWrite). If both MemRead and MemWrite are set, treat it as a write.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no mem_op:
  - 1-cycle latency: the next edge loads MEM/WB from the inputs.
  - mem_wb_valid = ex_mem_valid; mem_wb_read_data = 0.
- IDLE, mem_op with addr[1:0]!=0:
  - No bus access.
  - Set misalign_fault; next edge writes a bubble (mem_wb_valid=0). No stall.
- IDLE, aligned mem_op:
  - Latch the inputs internally; next edge -> ACCESS.
  - Registered dmem_req=1; dmem_we/addr/wdata come from the latched values.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ready.
  - On dmem_ready=1: capture dmem_rdata (loads) or 0 (stores), drop dmem_req at the next edge, -> DONE.
  - The counter increments each ACCESS cycle without ready. When it reaches TIMEOUT_CYCLES: drop dmem_req, set bus_error, -> DONE with a bubble.
- DONE (one cycle):
  - MEM/WB is loaded from the latched fields plus the captured data.
  - mem_wb_valid = 1, or 0 if timed out.
  - Then -> IDLE.
- stall = (state != IDLE) | (state == IDLE & aligned mem_op).
  - Held from the accepting cycle through the DONE cycle, so an aligned load with zero wait states costs 3 cycles.
  - Every cycle in which stall=1 and state is not DONE writes a bubble into MEM/WB (mem_wb_valid=0).
- Branch:
  - pc_src <= ex_mem_valid & Branch & zero_flag & ~stall.
  - branch_target <= ex_mem_pc.
  - Both are registered for one cycle. pc_src is 0 on the cycle after any cycle where the condition is false.
  - Branch instructions do not access memory.
- Write data: full 32-bit word only. No byte or halfword enables.
- Arithmetic: no address computation here; dmem_addr = latched ALU result unmodified.
- Sticky flags clear only on reset.

Test Plan:
- ALU op: valid=1, RegWrite=1, ALU_result=0x0000_0055, rd=5 -> next cycle mem_wb_valid=1, ALU_result=0x55, read_data=0, rd=5; stall never high.
- Load, 0-wait: MemRead=1, addr=0x100, bus returns ready with rdata=0xDEAD_BEEF in the first ACCESS cycle:
  - dmem_req high for 1 cycle, stall high for 3 cycles.
  - mem_wb_read_data=0xDEAD_BEEF with mem_wb_valid=1 in DONE.
- Store, 3 waits: MemWrite=1, addr=0x200, data=0x1234_5678, ready after 3 cycles:
  - dmem_we=1; addr and wdata are stable for all 4 request cycles.
  - Bubbles are written during the stall; one valid MEM/WB entry is written at the end.
- Timeout: MemRead to an address whose bus never answers:
  - After 16 ACCESS cycles, dmem_req=0 and bus_error=1.
  - A bubble reaches MEM/WB, then the next ALU op proceeds normally.
- Misaligned: MemRead with addr=0x102 -> dmem_req stays 0, misalign_fault=1, mem_wb_valid=0, stall=0.
- Branch and reset:
  - Branch=1, zero_flag=1, pc=0x40 -> pc_src=1 and branch_target=0x40 for exactly one cycle. The same with zero_flag=0 -> pc_src stays 0.
  - res_n=0 during an ACCESS cycle -> all outputs 0 at the next edge, FSM in IDLE.
